// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Includes access sizes, FSM states, byte strobes and the alignment rule.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Reserved encodings fall into the default arm, so they are aligned like words.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return off[0];
         default:     return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus between the MEM stage and data memory.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [3:0]        bus_wstrb;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// Purely combinational; the load side is also used by the WB-side load path.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      wstrb = STRB_W;
      wdata = st_data;
      case (st_funct3)
         F3_B, F3_BU: begin
            wstrb = STRB_B << st_off;
            wdata = {4{st_data[7:0]}};
         end
         F3_H, F3_HU: begin
            wstrb = STRB_H << st_off;
            wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
   assign ld_half = rdata[{ld_off[1], 4'b0000} +: 16];

   always_comb begin
      load_data = rdata;
      case (ld_funct3)
         F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_data = {24'h0, ld_byte};
         F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_data = {16'h0, ld_half};
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one bus transaction per access, stalls the
// pipeline while it is in flight and returns the extended load result.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_read_MEM,
   input  logic               mem_write_MEM,
   input  logic [2:0]         funct3_MEM,
   input  logic [ADDR_W-1:0]  addr_MEM,
   input  logic [DATA_W-1:0]  reg2_MEM,
   input  logic               bubbleM,
   input  logic               flushM,
   mem_access_unit_if.master  mem,
   output logic [DATA_W-1:0]  load_data_MEM,
   output logic               stall_mem,
   output logic               misalign_MEM
);
   state_e            state_q, state_d;
   logic              access, valid, issue, ack_busy;
   logic              we_q, drop_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, load_data_q;
   logic [3:0]        wstrb_q;
   logic [2:0]        ld_f3_q;
   logic [1:0]        ld_off_q;
   logic [31:0]       st_wdata, ld_data;
   logic [3:0]        st_wstrb;

   assign access       = mem_read_MEM | mem_write_MEM;
   assign misalign_MEM = access & is_misaligned(funct3_MEM, addr_MEM[1:0]);
   assign valid        = access & ~flushM & ~misalign_MEM;
   assign issue        = (state_q == IDLE) & valid;
   assign ack_busy     = (state_q == BUSY) & mem.bus_ack;

   mem_lane_align u_lane_align (
      .st_funct3 (funct3_MEM),
      .st_off    (addr_MEM[1:0]),
      .st_data   (reg2_MEM),
      .wstrb     (st_wstrb),
      .wdata     (st_wdata),
      .ld_funct3 (ld_f3_q),
      .ld_off    (ld_off_q),
      .rdata     (mem.bus_rdata),
      .load_data (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid) state_d = BUSY;
         BUSY:    if (mem.bus_ack) state_d = DONE;
         DONE:    if (!bubbleM) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_mem   = issue | (state_q == BUSY);
      mem.bus_req = (state_q == BUSY);
   end

   // A flushed load must still wait for its ack, but its data is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= STRB_NONE;
         ld_f3_q     <= F3_W;
         ld_off_q    <= 2'b00;
         drop_q      <= 1'b0;
         load_data_q <= '0;
      end else begin
         if (issue) begin
            we_q     <= mem_write_MEM;
            addr_q   <= {addr_MEM[ADDR_W-1:2], 2'b00};
            wdata_q  <= mem_write_MEM ? st_wdata : '0;
            wstrb_q  <= mem_write_MEM ? st_wstrb : STRB_NONE;
            ld_f3_q  <= funct3_MEM;
            ld_off_q <= addr_MEM[1:0];
            drop_q   <= 1'b0;
         end else if ((state_q == BUSY) && flushM) begin
            drop_q <= 1'b1;
         end
         if (ack_busy && !we_q && !drop_q && !flushM) begin
            load_data_q <= ld_data;
         end
      end
   end

   assign mem.bus_we    = we_q;
   assign mem.bus_addr  = addr_q;
   assign mem.bus_wdata = wdata_q;
   assign mem.bus_wstrb = wstrb_q;
   assign load_data_MEM = load_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses checked against a size/offset arithmetic model of the access rules.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read_MEM = 1'b0, mem_write_MEM = 1'b0;
   logic [2:0]  funct3_MEM = 3'b000;
   logic [31:0] addr_MEM = '0, reg2_MEM = '0;
   logic        bubbleM = 1'b0, flushM = 1'b0;
   logic [31:0] load_data_MEM;
   logic        stall_mem, misalign_MEM;

   int total = 0;
   int bad = 0;
   logic [31:0] ld_model = '0;

   logic        obs_req_seen, obs_mis, obs_we, obs_unstable, obs_reissue, obs_timeout;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_wstrb;
   int          obs_stall;

   mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_read_MEM  (mem_read_MEM),
      .mem_write_MEM (mem_write_MEM),
      .funct3_MEM    (funct3_MEM),
      .addr_MEM      (addr_MEM),
      .reg2_MEM      (reg2_MEM),
      .bubbleM       (bubbleM),
      .flushM        (flushM),
      .mem           (bus_if),
      .load_data_MEM (load_data_MEM),
      .stall_mem     (stall_mem),
      .misalign_MEM  (misalign_MEM)
   );

   always #5 clk = ~clk;

   function automatic int acc_size(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
      return (a % acc_size(f3)) != 0;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] s;
      if (acc_size(f3) == 4) return 4'hF;
      s = ((acc_size(f3) == 1) ? 32'd1 : 32'd3) << (a % 4);
      return s[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (acc_size(f3) == 1) return (d % 256) * 32'h0101_0101;
      if (acc_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
      int sz;
      logic [31:0] v, top;
      sz = acc_size(f3);
      if (sz == 4) return rd;
      v   = (rd >> (8 * (a % 4))) % (32'd1 << (8 * sz));
      top = 32'd1 << (8 * sz - 1);
      if (!f3[2] && v >= top) v = v - (top << 1);
      return v;
   endfunction

   // Drives one MEM-stage access and plays the memory side; records observations.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] rdata, input int dly,
                             input logic flush_busy, input int bub);
      int  req_cyc;
      bit  done;
      obs_req_seen = 0; obs_unstable = 0; obs_reissue = 0; obs_timeout = 0;
      obs_stall = 0; obs_mis = 0; req_cyc = 0; done = 0;
      @(negedge clk);
      mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
      addr_MEM = addr; reg2_MEM = rs2; bubbleM = 0; flushM = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (c == 0) obs_mis = misalign_MEM;
         bus_if.bus_ack = 1'b0;
         if (bus_if.bus_req) begin
            if (!obs_req_seen) begin
               obs_we = bus_if.bus_we; obs_addr = bus_if.bus_addr;
               obs_wdata = bus_if.bus_wdata; obs_wstrb = bus_if.bus_wstrb;
            end else if ({obs_we, obs_addr, obs_wdata, obs_wstrb} !==
                         {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb}) begin
               obs_unstable = 1;
            end
            obs_req_seen = 1;
            if (flush_busy) flushM = 1;
            if (req_cyc == dly) begin
               bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
            end else begin
               bus_if.bus_rdata = $urandom;
            end
            req_cyc++;
         end
         if (stall_mem) obs_stall++;
         else begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      if (!done) obs_timeout = 1;
      bubbleM = (bub > 0);
      for (int b = 0; b < bub; b++) begin
         @(negedge clk); #1;
         if (bus_if.bus_req || stall_mem) obs_reissue = 1;
      end
      mem_read_MEM = 0; mem_write_MEM = 0; flushM = 0; bubbleM = 0;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0; bus_if.bus_ack = 0; bus_if.bus_rdata = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb} !== '0) begin
         bad++;
         $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h wstrb=%b want all zero",
                  bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb);
      end
      total++;
      if ({load_data_MEM, stall_mem, misalign_MEM} !== '0) begin
         bad++;
         $display("FAIL reset_out: got load=%h stall=%b mis=%b want zeros",
                  load_data_MEM, stall_mem, misalign_MEM);
      end
      rst_n = 1;
   endtask

   task automatic test_store_word();
      run_access(0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, '0, 1, 0, 0);
      total++;
      if ({obs_req_seen, obs_we, obs_addr, obs_wstrb} !== {1'b1, 1'b1, 32'h1004, 4'hF}) begin
         bad++;
         $display("FAIL sw_bus: got seen=%b we=%b addr=%h wstrb=%b want 1 1 00001004 1111",
                  obs_req_seen, obs_we, obs_addr, obs_wstrb);
      end
      total++;
      if (obs_wdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata);
      end
      total++;
      if (obs_stall != 3 || obs_unstable || obs_timeout) begin
         bad++;
         $display("FAIL sw_stall: got stall=%0d unstable=%b timeout=%b want 3 0 0",
                  obs_stall, obs_unstable, obs_timeout);
      end
      total++;
      if ({bus_if.bus_req, stall_mem} !== 2'b00) begin
         bad++; $display("FAIL sw_after: got req=%b stall=%b want 0 0", bus_if.bus_req, stall_mem);
      end
   endtask

   task automatic test_store_byte();
      run_access(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, '0, 2, 0, 0);
      total++;
      if ({obs_wstrb, obs_wdata, obs_addr} !== {4'b1000, 32'hA5A5_A5A5, 32'h1000}) begin
         bad++;
         $display("FAIL sb_bus: got wstrb=%b wdata=%h addr=%h want 1000 a5a5a5a5 00001000",
                  obs_wstrb, obs_wdata, obs_addr);
      end
      total++;
      if (obs_stall != 4) begin
         bad++; $display("FAIL sb_stall: got %0d want 4", obs_stall);
      end
   endtask

   task automatic test_load_byte();
      run_access(1, 0, 3'b000, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 0, 0);
      ld_model = 32'hFFFF_FF80;
      total++;
      if (load_data_MEM !== ld_model) begin
         bad++; $display("FAIL lb_data: got %h want %h", load_data_MEM, ld_model);
      end
      total++;
      if ({obs_we, obs_wstrb, obs_addr, obs_stall} !== {1'b0, 4'h0, 32'h2000, 32'd2}) begin
         bad++;
         $display("FAIL lb_bus: got we=%b wstrb=%b addr=%h stall=%0d want 0 0000 00002000 2",
                  obs_we, obs_wstrb, obs_addr, obs_stall);
      end
      run_access(1, 0, 3'b100, 32'h0000_2002, 32'h0, 32'h1280_3456, 1, 0, 3);
      ld_model = 32'h0000_0080;
      total++;
      if (load_data_MEM !== ld_model) begin
         bad++; $display("FAIL lbu_data: got %h want %h", load_data_MEM, ld_model);
      end
      total++;
      if (obs_reissue) begin
         bad++; $display("FAIL done_bubble: got reissue=1 want 0");
      end
   endtask

   task automatic test_misalign();
      run_access(1, 0, 3'b001, 32'h0000_2001, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
      total++;
      if ({obs_mis, obs_req_seen, obs_stall} !== {1'b1, 1'b0, 32'd0}) begin
         bad++;
         $display("FAIL lh_misalign: got mis=%b req=%b stall=%0d want 1 0 0",
                  obs_mis, obs_req_seen, obs_stall);
      end
      total++;
      if (load_data_MEM !== ld_model) begin
         bad++; $display("FAIL lh_misalign_data: got %h want %h", load_data_MEM, ld_model);
      end
   endtask

   task automatic test_flush_busy();
      run_access(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1111_1111, 4, 1, 0);
      total++;
      if (obs_stall != 6 || obs_timeout) begin
         bad++; $display("FAIL flush_stall: got %0d timeout=%b want 6 0", obs_stall, obs_timeout);
      end
      total++;
      if (load_data_MEM !== ld_model) begin
         bad++; $display("FAIL flush_data: got %h want %h", load_data_MEM, ld_model);
      end
      total++;
      if ({bus_if.bus_req, stall_mem} !== 2'b00) begin
         bad++;
         $display("FAIL flush_idle: got req=%b stall=%b want 0 0", bus_if.bus_req, stall_mem);
      end
   endtask

   task automatic test_random();
      logic        rd, mis;
      logic [2:0]  f3;
      logic [31:0] a, d, r;
      int          dly, exp_stall;
      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
         a = $urandom; d = $urandom; r = $urandom; dly = $urandom_range(0, 3);
         mis = exp_mis(f3, a);
         run_access(rd, !rd, f3, a, d, r, dly, 0, $urandom_range(0, 2));
         exp_stall = mis ? 0 : 2 + dly;
         total++;
         if (obs_mis !== mis || obs_stall != exp_stall) begin
            bad++;
            $display("FAIL rnd_stall[%0d]: got mis=%b stall=%0d want %b %0d",
                     i, obs_mis, obs_stall, mis, exp_stall);
         end
         if (!mis) begin
            total++;
            if ({obs_we, obs_addr, obs_wstrb} !==
                {!rd, a & 32'hFFFF_FFFC, rd ? 4'h0 : exp_strb(f3, a)}) begin
               bad++;
               $display("FAIL rnd_bus[%0d]: got we=%b addr=%h wstrb=%b want %b %h %b", i,
                        obs_we, obs_addr, obs_wstrb, !rd, a & 32'hFFFF_FFFC, exp_strb(f3, a));
            end
            if (!rd) begin
               total++;
               if (obs_wdata !== exp_wdata(f3, d)) begin
                  bad++;
                  $display("FAIL rnd_wdata[%0d]: got %h want %h", i, obs_wdata, exp_wdata(f3, d));
               end
            end else begin
               ld_model = exp_load(f3, a, r);
            end
         end
         total++;
         if (load_data_MEM !== ld_model) begin
            bad++; $display("FAIL rnd_load[%0d]: got %h want %h", i, load_data_MEM, ld_model);
         end
         total++;
         if (obs_reissue || obs_unstable || obs_timeout) begin
            bad++;
            $display("FAIL rnd_proto[%0d]: got reissue=%b unstable=%b timeout=%b want 0 0 0",
                     i, obs_reissue, obs_unstable, obs_timeout);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      bit seen;
      seen = 0;
      @(negedge clk);
      mem_read_MEM = 1; funct3_MEM = 3'b010; addr_MEM = 32'h0000_4000;
      for (int c = 0; c < 5 && !seen; c++) begin
         @(negedge clk); #1;
         seen = bus_if.bus_req;
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL rst_busy_req: got req=0 want 1 before reset");
      end
      #2 rst_n = 0;
      #1;
      total++;
      if ({bus_if.bus_req, bus_if.bus_addr, load_data_MEM} !== '0) begin
         bad++;
         $display("FAIL rst_async: got req=%b addr=%h load=%h want zeros",
                  bus_if.bus_req, bus_if.bus_addr, load_data_MEM);
      end
      ld_model = '0;
      mem_read_MEM = 0;
      @(negedge clk); rst_n = 1;
      // Stray acks with no transaction in flight must be ignored.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); bus_if.bus_ack = 1; bus_if.bus_rdata = $urandom;
      end
      @(negedge clk); bus_if.bus_ack = 0; #1;
      total++;
      if ({bus_if.bus_req, stall_mem, load_data_MEM} !== '0) begin
         bad++;
         $display("FAIL stray_ack: got req=%b stall=%b load=%h want zeros",
                  bus_if.bus_req, stall_mem, load_data_MEM);
      end
      run_access(0, 1, 3'b001, 32'h0000_5006, 32'h0000_BEEF, '0, 0, 0, 0);
      total++;
      if ({obs_wstrb, obs_wdata, obs_addr, obs_stall} !==
          {4'b1100, 32'hBEEF_BEEF, 32'h5004, 32'd2}) begin
         bad++;
         $display("FAIL rst_reissue: got wstrb=%b wdata=%h addr=%h stall=%0d want 1100 beefbeef 00005004 2",
                  obs_wstrb, obs_wdata, obs_addr, obs_stall);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_store_byte();
      test_load_byte();
      test_misalign();
      test_flush_busy();
      test_random();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
